ram_arbiter: RTL

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_arbiter.sv | 69 ++++++
 1 files changed

// File: rtl/ram_arbiter.sv
// ram_arbiter: two-port round-robin arbiter in front of a single-port synchronous RAM,
// with an optional zero-fill pass after reset.
module ram_arbiter #(
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 16,
  parameter int CLEAR_ON_RESET = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  a_req,
  input  logic                  a_we,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  input  logic                  b_req,
  input  logic                  b_we,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  output logic                  a_gnt,
  output logic                  b_gnt,
  output logic                  a_rvalid,
  output logic                  b_rvalid,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [DATA_WIDTH-1:0] ram_data,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_we,
  input  logic [DATA_WIDTH-1:0] ram_q,
  output logic                  busy
);
  typedef enum logic {CLEAR, ARB} state_t;
  state_t state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic last_b_q, last_b_d;
  logic a_rvalid_q, a_rvalid_d, b_rvalid_q, b_rvalid_d;
  logic clr, arb;
  always_comb begin
    clr = !rst && state_q == CLEAR;
    arb = !rst && state_q == ARB;
    a_gnt = arb && a_req && (!b_req || last_b_q);
    b_gnt = arb && b_req && !a_gnt;
    ram_we = clr || (a_gnt && a_we) || (b_gnt && b_we);
    ram_addr = clr ? cnt_q : a_gnt ? a_addr : b_gnt ? b_addr : '0;
    ram_data = a_gnt ? a_wdata : b_gnt ? b_wdata : '0;
    cnt_d = clr ? cnt_q + 1'b1 : cnt_q;
    state_d = (clr && &cnt_q) ? ARB : state_q;
    last_b_d = b_gnt ? 1'b1 : a_gnt ? 1'b0 : last_b_q;
    a_rvalid_d = a_gnt && !a_we;
    b_rvalid_d = b_gnt && !b_we;
    a_rvalid = a_rvalid_q && !rst;
    b_rvalid = b_rvalid_q && !rst;
    busy = rst ? (CLEAR_ON_RESET != 0) : state_q == CLEAR;
    rdata = ram_q;
  end
  // B counts as last granted out of reset so A wins the first tie
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= (CLEAR_ON_RESET != 0) ? CLEAR : ARB;
      cnt_q <= '0;
      last_b_q <= 1'b1;
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      last_b_q <= last_b_d;
      a_rvalid_q <= a_rvalid_d;
      b_rvalid_q <= b_rvalid_d;
    end
  end
endmodule
